regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the next-generation bittyCore

---
 rtl/regfile_mp_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 35 +++
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the bittyCore multi-port register file.
// Optional scoreboard in regfile_mp is enabled by defining REGFILE_SCOREBOARD_EN.
package regfile_mp_pkg;

  typedef enum logic {
    RfClear = 1'b0,
    RfRun   = 1'b1
  } rf_state_e;

  localparam int unsigned DefDw    = 32;
  localparam int unsigned DefDepth = 32;

  localparam logic WeActive = 1'b1;
  localparam logic ReActive = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: enable/zero-register gating, write bypass, array mux.
// Highest-numbered write port wins the bypass when several target the same address.
module regfile_rd_port #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NW       = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             en_i,
  input  logic [AW-1:0]    raddr_i,
  input  logic [DW-1:0]    regs_i [DEPTH],
  input  logic [NW-1:0]    wvalid_i,
  input  logic [NW*AW-1:0] waddr_i,
  input  logic [NW*DW-1:0] wdata_i,
  output logic [DW-1:0]    rdata_o
);

  logic w_zero_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (raddr_i == '0);

  always_comb begin
    rdata_o = '0;
    if (en_i && !w_zero_hit) begin
      rdata_o = regs_i[raddr_i];
      for (int k = 0; k < int'(NW); k++) begin
        if (wvalid_i[k] && (waddr_i[k*AW +: AW] == raddr_i)) begin
          rdata_o = wdata_i[k*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with bypass and post-reset clear sweep.
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard (sb_set_i/sb_addr_i/busy_o).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW       = DefDw,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned NR       = 2,
  parameter int unsigned NW       = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready_o,
  input  logic [NW-1:0]    we_i,
  input  logic [NW*AW-1:0] waddr_i,
  input  logic [NW*DW-1:0] wdata_i,
  input  logic [NR-1:0]    re_i,
  input  logic [NR*AW-1:0] raddr_i,
  output logic [NR*DW-1:0] rdata_o
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic             sb_set_i,
  input  logic [AW-1:0]    sb_addr_i,
  output logic [NR-1:0]    busy_o
`endif
);

  rf_state_e     r_state, w_state_nxt;
  logic [AW-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic          r_ready, w_ready_nxt;
  logic          w_run;
  logic [DW-1:0] r_regs [DEPTH];
  logic [NW-1:0] w_wvalid;

  assign ready_o = r_ready;
  assign w_run   = (r_state == RfRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RfClear;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_ready_nxt   = r_ready;
    case (r_state)
      RfClear: begin
        w_clr_ptr_nxt = r_clr_ptr + AW'(1);
        if (r_clr_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = RfRun;
          w_ready_nxt = 1'b1;
        end
      end
      RfRun:   ;
      default: w_state_nxt = RfClear;
    endcase
  end

  // Writes to entry 0 are dropped entirely when it is hardwired, including for bypass.
  always_comb begin
    w_wvalid = '0;
    for (int k = 0; k < int'(NW); k++) begin
      w_wvalid[k] = w_run && (we_i[k] == WeActive) &&
                    !((ZERO_REG != 0) && (waddr_i[k*AW +: AW] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RfClear) begin
        r_regs[r_clr_ptr] <= '0;
      end else begin
        for (int k = 0; k < int'(NW); k++) begin
          if (w_wvalid[k]) begin
            r_regs[waddr_i[k*AW +: AW]] <= wdata_i[k*DW +: DW];
          end
        end
      end
    end
  end

  for (genvar j = 0; j < int'(NR); j++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .en_i     (w_run && (re_i[j] == ReActive)),
      .raddr_i  (raddr_i[j*AW +: AW]),
      .regs_i   (r_regs),
      .wvalid_i (w_wvalid),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .rdata_o  (rdata_o[j*DW +: DW])
    );
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  logic [NR-1:0]    w_wr_hit;

  // Same-cycle write clears, then issue sets, so a set on the same address wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      for (int k = 0; k < int'(NW); k++) begin
        if (w_wvalid[k]) w_busy_nxt[waddr_i[k*AW +: AW]] = 1'b0;
      end
      if (sb_set_i) w_busy_nxt[sb_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  always_comb begin
    w_wr_hit = '0;
    busy_o   = '0;
    for (int j = 0; j < int'(NR); j++) begin
      for (int k = 0; k < int'(NW); k++) begin
        if (w_wvalid[k] && (waddr_i[k*AW +: AW] == raddr_i[j*AW +: AW])) w_wr_hit[j] = 1'b1;
      end
      busy_o[j] = w_run && re_i[j] && r_busy[raddr_i[j*AW +: AW]] && !w_wr_hit[j];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (NR=2, NW=2, defaults otherwise).
module tb_regfile_mp;

  localparam int unsigned AW = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_o;
  logic [1:0]  we_i;
  logic [9:0]  waddr_i;
  logic [63:0] wdata_i;
  logic [1:0]  re_i;
  logic [9:0]  raddr_i;
  logic [63:0] rdata_o;
`ifdef REGFILE_SCOREBOARD_EN
  logic        sb_set_i;
  logic [4:0]  sb_addr_i;
  logic [1:0]  busy_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DW       (32),
    .DEPTH    (32),
    .NR       (2),
    .NW       (2),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready_o   (ready_o),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .re_i      (re_i),
    .raddr_i   (raddr_i),
    .rdata_o   (rdata_o)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .sb_set_i  (sb_set_i),
    .sb_addr_i (sb_addr_i),
    .busy_o    (busy_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle inputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    we_i    = '0;
    waddr_i = '0;
    wdata_i = '0;
    re_i    = '0;
    raddr_i = '0;
`ifdef REGFILE_SCOREBOARD_EN
    sb_set_i  = 1'b0;
    sb_addr_i = '0;
`endif
    tick();
    rst = 1'b0;
    re_i = 2'b11;
    raddr_i = {5'd6, 5'd5};
    #1;
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_rd0", rdata_o[31:0], 32'd0);

    // Sweep: writes during CLEAR must be ignored.
    we_i = 2'b01; waddr_i = {5'd0, 5'd5}; wdata_i = {32'd0, 32'h0BAD_0BAD};
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 1)  check("clear_rd0", rdata_o[31:0], 32'd0);
      if (c == 31) check("ready_c31", {31'd0, ready_o}, 32'd0);
      if (c == 31) we_i = 2'b00;
      if (c == 32) check("ready_c32", {31'd0, ready_o}, 32'd1);
    end
    #1;
    check("post_clear_x5", rdata_o[31:0], 32'd0);
    check("post_clear_x6", rdata_o[63:32], 32'd0);

    // Bypass then array read.
    we_i = 2'b01; waddr_i = {5'd0, 5'd5}; wdata_i = {32'd0, 32'hDEAD_BEEF};
    #1;
    check("bypass_x5", rdata_o[31:0], 32'hDEAD_BEEF);
    check("bypass_x6", rdata_o[63:32], 32'd0);
    tick();
    we_i = 2'b00;
    #1;
    check("array_x5", rdata_o[31:0], 32'hDEAD_BEEF);

    // Zero register, and disabled read port.
    we_i = 2'b01; waddr_i = {5'd0, 5'd0}; wdata_i = {32'd0, 32'h0000_1234};
    re_i = 2'b01; raddr_i = {5'd5, 5'd0};
    #1;
    check("x0_same", rdata_o[31:0], 32'd0);
    check("re_off", rdata_o[63:32], 32'd0);
    tick();
    we_i = 2'b00;
    #1;
    check("x0_next", rdata_o[31:0], 32'd0);

    // Two ports to the same register: port 1 wins.
    we_i = 2'b11; waddr_i = {5'd7, 5'd7}; wdata_i = {32'h22, 32'h11};
    re_i = 2'b11; raddr_i = {5'd7, 5'd7};
    #1;
    check("dual_same0", rdata_o[31:0], 32'h22);
    check("dual_same1", rdata_o[63:32], 32'h22);
    tick();
    we_i = 2'b00;
    #1;
    check("dual_next", rdata_o[31:0], 32'h22);

    // Reset mid-sweep restarts the clear.
    we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'd0, 32'hA5};
    tick();
    we_i = 2'b00; raddr_i = {5'd7, 5'd9};
    #1;
    check("x9_written", rdata_o[31:0], 32'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we_i = 2'b01; waddr_i = {5'd0, 5'd9}; wdata_i = {32'd0, 32'h77};
    for (int c = 1; c <= 4; c++) tick();
    check("sweep4_ready", {31'd0, ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c == 31) check("restart_c31", {31'd0, ready_o}, 32'd0);
      if (c == 31) we_i = 2'b00;
      if (c == 32) check("restart_c32", {31'd0, ready_o}, 32'd1);
    end
    #1;
    check("x9_cleared", rdata_o[31:0], 32'd0);
    check("x7_cleared", rdata_o[63:32], 32'd0);

`ifdef REGFILE_SCOREBOARD_EN
    sb_set_i = 1'b1; sb_addr_i = 5'd3;
    tick();
    sb_set_i = 1'b0;
    re_i = 2'b01; raddr_i = {5'd0, 5'd3};
    #1;
    check("sb_busy", {30'd0, busy_o}, 32'd1);
    we_i = 2'b01; waddr_i = {5'd0, 5'd3}; wdata_i = {32'd0, 32'h55};
    #1;
    check("sb_bypass_busy", {30'd0, busy_o}, 32'd0);
    check("sb_bypass_data", rdata_o[31:0], 32'h55);
    tick();
    we_i = 2'b00;
    #1;
    check("sb_cleared", {30'd0, busy_o}, 32'd0);
    sb_set_i = 1'b1; sb_addr_i = 5'd3;
    we_i = 2'b01; waddr_i = {5'd0, 5'd3}; wdata_i = {32'd0, 32'h66};
    tick();
    sb_set_i = 1'b0; we_i = 2'b00;
    #1;
    check("sb_set_wins", {30'd0, busy_o}, 32'd1);
    check("sb_set_data", rdata_o[31:0], 32'h66);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
